// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg
// Shared constants for the commit sequencer:
//   - ROB_BIT_DEF : default ROB index width
//   - CT_*        : head_type encodings (REG, STORE, BRANCH, HALT)
//   - state_e     : commit FSM state encoding
package commit_ctrl_pkg;

  localparam int ROB_BIT_DEF = 4;

  localparam logic [1:0] CT_REG    = 2'd0;
  localparam logic [1:0] CT_STORE  = 2'd1;
  localparam logic [1:0] CT_BRANCH = 2'd2;
  localparam logic [1:0] CT_HALT   = 2'd3;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2,
    S_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/commit_ctrl_chk.sv
// commit_ctrl_chk
// Protocol checker for commit_ctrl: the ROB head must stay valid while a
// store request is outstanding (st_req high only in the store-wait state).
// Ports: clk_in, rst_in, st_req, head_valid (all observed, no outputs).
module commit_ctrl_chk (
  input logic clk_in,
  input logic rst_in,
  input logic st_req,
  input logic head_valid
);

  // Head must not disappear under an in-flight store
  a_head_held : assert property (@(posedge clk_in) disable iff (rst_in)
                                 !(st_req && !head_valid))
    else $fatal(1, "commit_ctrl protocol error: head_valid dropped during store wait");

endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl
// In-order commit sequencer sitting between the ROB head and the register
// file, store port and fetch redirect.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low freezes the block)
//   head_*            : ROB head entry description
//   rob_pop           : combinational, retire the head this cycle
//   rob_commit/commit_*: registered register-file write pulse and payload
//   st_req/st_entry   : registered store request, held until st_done
//   rob_clear_up, redirect_valid/redirect_pc : registered flush + redirect
//   halted            : sticky halt flag
//   commit_cnt        : retired-instruction counter (wraps)
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               head_valid,
  input  logic               head_ready,
  input  logic [1:0]         head_type,
  input  logic [4:0]         head_rd,
  input  logic [31:0]        head_value,
  input  logic [ROB_BIT-1:0] head_entry,
  input  logic               head_mispredict,
  input  logic [31:0]        head_target,
  output logic               rob_pop,
  output logic               rob_commit,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               st_req,
  output logic [ROB_BIT-1:0] st_entry,
  input  logic               st_done,
  output logic               rob_clear_up,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               halted,
  output logic [31:0]        commit_cnt
);

  state_e               r_state;
  logic                 r_rob_commit;
  logic [4:0]           r_commit_reg_id;
  logic [31:0]          r_commit_reg_data;
  logic [ROB_BIT-1:0]   r_commit_rob_entry;
  logic                 r_st_req;
  logic [ROB_BIT-1:0]   r_st_entry;
  logic                 r_flush;
  logic [31:0]          r_redirect_pc;
  logic                 r_halted;
  logic [31:0]          r_commit_cnt;

  state_e               w_state_nxt;
  logic                 w_head_go;
  logic                 w_pop;
  logic                 w_commit;
  logic                 w_flush;
  logic                 w_st_req_nxt;
  logic                 w_st_load;
  logic                 w_halt_set;

  // Next-state and retirement decision for the current head entry
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_commit     = 1'b0;
    w_flush      = 1'b0;
    w_st_req_nxt = r_st_req;
    w_st_load    = 1'b0;
    w_halt_set   = 1'b0;
    w_head_go    = head_valid && head_ready;
    // Gating with rst_in keeps rob_pop low while reset is applied.
    if (rdy_in && !rst_in) begin
      case (r_state)
        S_RUN: begin
          if (w_head_go) begin
            case (head_type)
              CT_STORE: begin
                // Store is not popped until the LSB reports completion.
                w_st_req_nxt = 1'b1;
                w_st_load    = 1'b1;
                w_state_nxt  = S_ST_WAIT;
              end
              CT_HALT: begin
                w_pop       = 1'b1;
                w_halt_set  = 1'b1;
                w_state_nxt = S_HALT;
              end
              CT_BRANCH: begin
                // rd carries the JAL/JALR link; x0 is never written.
                w_pop    = 1'b1;
                w_commit = (head_rd != 5'd0);
                if (head_mispredict) begin
                  w_flush     = 1'b1;
                  w_state_nxt = S_FLUSH;
                end else begin
                  w_state_nxt = S_RUN;
                end
              end
              default: begin
                w_pop    = 1'b1;
                w_commit = (head_rd != 5'd0);
              end
            endcase
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_ST_WAIT: begin
          if (st_done) begin
            w_pop        = 1'b1;
            w_st_req_nxt = 1'b0;
            w_state_nxt  = S_RUN;
          end else begin
            w_state_nxt = S_ST_WAIT;
          end
        end
        S_FLUSH: w_state_nxt = S_RUN;
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_RUN;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, output registers and retirement counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state            <= S_RUN;
      r_rob_commit       <= 1'b0;
      r_commit_reg_id    <= 5'd0;
      r_commit_reg_data  <= 32'd0;
      r_commit_rob_entry <= '0;
      r_st_req           <= 1'b0;
      r_st_entry         <= '0;
      r_flush            <= 1'b0;
      r_redirect_pc      <= 32'd0;
      r_halted           <= 1'b0;
      r_commit_cnt       <= 32'd0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_rob_commit <= w_commit;
      r_flush      <= w_flush;
      r_st_req     <= w_st_req_nxt;
      if (w_commit) begin
        r_commit_reg_id    <= head_rd;
        r_commit_reg_data  <= head_value;
        r_commit_rob_entry <= head_entry;
      end
      if (w_flush) begin
        r_redirect_pc <= head_target;
      end
      if (w_st_load) begin
        r_st_entry <= head_entry;
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
      if (w_pop) begin
        r_commit_cnt <= r_commit_cnt + 32'd1;
      end
    end else begin
      // Frozen: everything holds except the one-cycle pulses.
      r_rob_commit <= 1'b0;
      r_flush      <= 1'b0;
    end
  end

  assign rob_pop          = w_pop;
  assign rob_commit       = r_rob_commit;
  assign commit_reg_id    = r_commit_reg_id;
  assign commit_reg_data  = r_commit_reg_data;
  assign commit_rob_entry = r_commit_rob_entry;
  assign st_req           = r_st_req;
  assign st_entry         = r_st_entry;
  assign rob_clear_up     = r_flush;
  assign redirect_valid   = r_flush;
  assign redirect_pc      = r_redirect_pc;
  assign halted           = r_halted;
  assign commit_cnt       = r_commit_cnt;

endmodule

// File: tb/tb_commit_ctrl.sv
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        head_valid, head_ready, head_mispredict, st_done;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic [31:0] head_value, head_target;
  logic [3:0]  head_entry;
  logic        rob_pop, rob_commit, st_req, rob_clear_up, redirect_valid, halted;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_data, redirect_pc, commit_cnt;
  logic [3:0]  commit_rob_entry, st_entry;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  commit_ctrl #(.ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
    .head_rd(head_rd), .head_value(head_value), .head_entry(head_entry),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .rob_pop(rob_pop), .rob_commit(rob_commit), .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
    .st_req(st_req), .st_entry(st_entry), .st_done(st_done),
    .rob_clear_up(rob_clear_up), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .commit_cnt(commit_cnt)
  );

  commit_ctrl_chk chk (
    .clk_in(clk_in), .rst_in(rst_in), .st_req(st_req), .head_valid(head_valid)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_head(input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] val, input logic [3:0] ent,
                          input logic mis, input logic [31:0] tgt);
    head_valid = 1'b1; head_ready = 1'b1; head_type = t; head_rd = rd;
    head_value = val; head_entry = ent; head_mispredict = mis; head_target = tgt;
  endtask

  task automatic set_idle;
    head_valid = 1'b0; head_ready = 1'b0; head_type = CT_REG; head_rd = 5'd0;
    head_value = 32'd0; head_entry = 4'd0; head_mispredict = 1'b0; head_target = 32'd0;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; st_done = 1'b0; set_idle();
    tick(); tick();
    rst_in = 1'b0;
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if ({rob_commit, st_req, rob_clear_up, redirect_valid} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {rob_commit, st_req, rob_clear_up, redirect_valid}); end
    checks++; if (redirect_pc !== 32'd0 || commit_reg_data !== 32'd0) begin errors++; $display("FAIL reset_data: got pc=%h data=%h want 0", redirect_pc, commit_reg_data); end
    // st_done with no store outstanding is ignored
    st_done = 1'b1; #1;
    checks++; if (rob_pop !== 1'b0) begin errors++; $display("FAIL stray_done_pop: got %b want 0", rob_pop); end
    tick(); st_done = 1'b0;
    checks++; if (commit_cnt !== 32'd0 || st_req !== 1'b0) begin errors++; $display("FAIL stray_done_state: got cnt=%0d st_req=%b want 0/0", commit_cnt, st_req); end
  endtask

  task automatic test_reg;
    set_head(CT_REG, 5'd5, 32'h1234, 4'd3, 1'b0, 32'd0); #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL reg_pop: got %b want 1", rob_pop); end
    tick(); set_idle();
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd5 || commit_reg_data !== 32'h1234 || commit_rob_entry !== 4'd3)
      begin errors++; $display("FAIL reg_commit: got %b id=%0d data=%h ent=%0d want 1/5/1234/3", rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry); end
    checks++; if (commit_cnt !== 32'd1) begin errors++; $display("FAIL reg_cnt: got %0d want 1", commit_cnt); end
    tick();
    checks++; if (rob_commit !== 1'b0) begin errors++; $display("FAIL reg_pulse_end: got %b want 0", rob_commit); end
  endtask

  task automatic test_rd0;
    set_head(CT_REG, 5'd0, 32'hDEAD, 4'd4, 1'b0, 32'd0); #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL rd0_pop: got %b want 1", rob_pop); end
    tick(); set_idle();
    checks++; if (rob_commit !== 1'b0 || commit_cnt !== 32'd2) begin errors++; $display("FAIL rd0_commit: got %b cnt=%0d want 0/2", rob_commit, commit_cnt); end
  endtask

  task automatic test_store;
    set_head(CT_STORE, 5'd0, 32'd0, 4'd7, 1'b0, 32'd0); #1;
    checks++; if (rob_pop !== 1'b0) begin errors++; $display("FAIL st_nopop_run: got %b want 0", rob_pop); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (st_req !== 1'b1 || st_entry !== 4'd7 || rob_pop !== 1'b0)
        begin errors++; $display("FAIL st_wait%0d: got req=%b ent=%0d pop=%b want 1/7/0", i, st_req, st_entry, rob_pop); end
      tick();
    end
    st_done = 1'b1; #1;
    checks++; if (st_req !== 1'b1 || rob_pop !== 1'b1) begin errors++; $display("FAIL st_done_pop: got req=%b pop=%b want 1/1", st_req, rob_pop); end
    tick(); st_done = 1'b0; set_idle();
    checks++; if (st_req !== 1'b0 || commit_cnt !== 32'd3 || rob_commit !== 1'b0)
      begin errors++; $display("FAIL st_end: got req=%b cnt=%0d commit=%b want 0/3/0", st_req, commit_cnt, rob_commit); end
  endtask

  task automatic test_mispredict;
    set_head(CT_BRANCH, 5'd1, 32'h20, 4'd2, 1'b1, 32'h100); #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL mp_pop: got %b want 1", rob_pop); end
    tick();
    set_head(CT_REG, 5'd9, 32'hABCD, 4'd4, 1'b0, 32'd0); #1;
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd1 || commit_reg_data !== 32'h20 || commit_rob_entry !== 4'd2)
      begin errors++; $display("FAIL mp_link: got %b id=%0d data=%h ent=%0d want 1/1/20/2", rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry); end
    checks++; if (rob_clear_up !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h100)
      begin errors++; $display("FAIL mp_flush: got clr=%b rv=%b pc=%h want 1/1/100", rob_clear_up, redirect_valid, redirect_pc); end
    checks++; if (rob_pop !== 1'b0 || commit_cnt !== 32'd4) begin errors++; $display("FAIL mp_flush_nopop: got pop=%b cnt=%0d want 0/4", rob_pop, commit_cnt); end
    tick();
    checks++; if (rob_clear_up !== 1'b0 || redirect_valid !== 1'b0 || rob_commit !== 1'b0)
      begin errors++; $display("FAIL mp_after: got clr=%b rv=%b commit=%b want 0/0/0", rob_clear_up, redirect_valid, rob_commit); end
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL mp_resume_pop: got %b want 1", rob_pop); end
    tick();
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd9 || commit_cnt !== 32'd5)
      begin errors++; $display("FAIL mp_resume_commit: got %b id=%0d cnt=%0d want 1/9/5", rob_commit, commit_reg_id, commit_cnt); end
  endtask

  task automatic test_rdy_freeze;
    rdy_in = 1'b0;
    set_head(CT_REG, 5'd12, 32'h55AA, 4'd5, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (rob_pop !== 1'b0) begin errors++; $display("FAIL rdy_pop%0d: got %b want 0", i, rob_pop); end
      tick();
      checks++; if (rob_commit !== 1'b0 || commit_cnt !== 32'd5)
        begin errors++; $display("FAIL rdy_hold%0d: got commit=%b cnt=%0d want 0/5", i, rob_commit, commit_cnt); end
    end
    rdy_in = 1'b1; #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL rdy_release_pop: got %b want 1", rob_pop); end
    tick(); set_idle();
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd12 || commit_reg_data !== 32'h55AA || commit_cnt !== 32'd6)
      begin errors++; $display("FAIL rdy_release_commit: got %b id=%0d data=%h cnt=%0d want 1/12/55aa/6", rob_commit, commit_reg_id, commit_reg_data, commit_cnt); end
  endtask

  task automatic test_back_to_back;
    set_head(CT_REG, 5'd3, 32'h11, 4'd6, 1'b0, 32'd0); #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop0: got %b want 1", rob_pop); end
    tick();
    set_head(CT_BRANCH, 5'd4, 32'h22, 4'd7, 1'b0, 32'h999); #1;
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd3 || commit_reg_data !== 32'h11)
      begin errors++; $display("FAIL b2b_commit0: got %b id=%0d data=%h want 1/3/11", rob_commit, commit_reg_id, commit_reg_data); end
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop1: got %b want 1", rob_pop); end
    tick(); set_idle();
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd4 || commit_reg_data !== 32'h22 || commit_cnt !== 32'd8 || rob_clear_up !== 1'b0)
      begin errors++; $display("FAIL b2b_commit1: got %b id=%0d data=%h cnt=%0d clr=%b want 1/4/22/8/0", rob_commit, commit_reg_id, commit_reg_data, commit_cnt, rob_clear_up); end
  endtask

  task automatic test_halt_reset;
    set_head(CT_HALT, 5'd0, 32'd0, 4'd8, 1'b0, 32'd0); #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL halt_pop: got %b want 1", rob_pop); end
    tick();
    checks++; if (halted !== 1'b1 || commit_cnt !== 32'd9 || rob_commit !== 1'b0)
      begin errors++; $display("FAIL halt_state: got halted=%b cnt=%0d commit=%b want 1/9/0", halted, commit_cnt, rob_commit); end
    set_head(CT_REG, 5'd7, 32'h77, 4'd9, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rob_pop !== 1'b0) begin errors++; $display("FAIL halt_nopop%0d: got %b want 0", i, rob_pop); end
      tick();
    end
    checks++; if (halted !== 1'b1 || commit_cnt !== 32'd9) begin errors++; $display("FAIL halt_sticky: got halted=%b cnt=%0d want 1/9", halted, commit_cnt); end
    rst_in = 1'b1; #1;
    checks++; if (rob_pop !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b want 0", rob_pop); end
    tick(); rst_in = 1'b0;
    checks++; if (halted !== 1'b0 || commit_cnt !== 32'd0 || rob_commit !== 1'b0 || st_req !== 1'b0)
      begin errors++; $display("FAIL rst_clear: got halted=%b cnt=%0d commit=%b st_req=%b want 0/0/0/0", halted, commit_cnt, rob_commit, st_req); end
    #1;
    checks++; if (rob_pop !== 1'b1) begin errors++; $display("FAIL rst_run_pop: got %b want 1", rob_pop); end
    tick(); set_idle();
    checks++; if (rob_commit !== 1'b1 || commit_reg_id !== 5'd7 || commit_cnt !== 32'd1)
      begin errors++; $display("FAIL rst_run_commit: got %b id=%0d cnt=%0d want 1/7/1", rob_commit, commit_reg_id, commit_cnt); end
  endtask

  initial begin
    test_reset();
    test_reg();
    test_rd0();
    test_store();
    test_mispredict();
    test_rdy_freeze();
    test_back_to_back();
    test_halt_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
